seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Receive-side counterpart of the hex-to-7-segment encoder. Samples a multiplexed, active-low 7-segment display bus (segment lines plus one-hot digit strobes), waits until each digit's pattern is stable, and decodes it back to a 4-bit hex nibble per digit. Used to read back a scanned LED display, either our own or an external one, into register form for compare, logging, or self-test.

## Interface
- `DIGITS`, 4: number of scanned digits (1–8).
- `STABLE_CYCLES`, 4: consecutive identical samples required before commit (2–255).

- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `iSeg`  in  [0:6]  segment lines, active-low; bit 0 = a … bit 6 = g.
- `iDigEn`  in  [DIGITS-1:0]  digit strobes, active-high, one-hot when valid.
- `oValue`  out  [4*DIGITS-1:0]  decoded nibbles; digit d at bits [4d+3:4d].
- `oValid`  out  [DIGITS-1:0]  digit d holds a decoded hex pattern.
- `oBlank`  out  [DIGITS-1:0]  digit d last committed all-off (7'b1111111).
- `oErr`  out  [DIGITS-1:0]  digit d last committed an unrecognised pattern.
- `oUpdate`  out  1  one-cycle pulse on each commit.
- `oDigIdx`  out  [2:0]  index of the digit committed; meaningful while `oUpdate`=1.

## Operation
- Input stage: `iSeg` and `iDigEn` are registered once each cycle into `sSeg` and `sEn`. The previous sample is also kept for comparison. Any CDC synchroniser sits outside this block.
- Decode table (iSeg[0:6] → nibble): 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9, 0001000→A, 1100000→B, 0110001→C, 1000010→D, 0110000→E, 0111000→F. The pattern 1111111 is blank. Every other pattern is an error.
- FSM states:
  - IDLE: `sEn` is not one-hot (zero bits set or more than one).
  - SETTLE: a one-hot sample is being counted. Counter `cnt` has width 8.
  - HELD: the current sample has been committed. Wait for it to change.
- Transitions, evaluated every edge from the current registered sample:
  - `sEn` not one-hot → IDLE, `cnt`=0. This applies from any state.
  - One-hot sample differs from the previous sample (either the strobe or the segments changed) → SETTLE, `cnt`=1.
  - In SETTLE with the sample unchanged and `cnt` < STABLE_CYCLES-1 → `cnt`+1.
  - In SETTLE with the sample unchanged and `cnt` = STABLE_CYCLES-1 → commit, go to HELD.
  - In HELD with the sample unchanged → stay, no further commits.
- Commit to digit d (the index of the set bit in `sEn`):
  - Hex pattern: `oValue[d]` = nibble; `oValid[d]`=1; `oBlank[d]`=0; `oErr[d]`=0.
  - Blank pattern: `oValid[d]`=0; `oBlank[d]`=1; `oErr[d]`=0; nibble unchanged.
  - Error pattern: `oValid[d]`=0; `oBlank[d]`=0; `oErr[d]`=1; nibble unchanged.
  - In all cases: `oUpdate`=1 and `oDigIdx`=d for exactly one cycle.
  - Other digits' outputs are untouched.
- Re-committing an identical pattern after a strobe change is a normal commit, and `oUpdate` pulses again.

## Timing
- Reset (`rst_n`=0 at an edge):
  - `oValue`=0, `oValid`=0, `oBlank`=0, `oErr`=0, `oUpdate`=0, `oDigIdx`=0.
  - State IDLE, `cnt`=0.
  - Sample registers cleared to `sEn`=0 and `sSeg`=7'b1111111.
  - Reset takes priority over all other activity. A reset during SETTLE discards the partial count.
- Latency, for inputs applied before edge 0 and held:
  - Edge 0: inputs registered.
  - Edge 1: FSM enters SETTLE, `cnt`=1.
  - Edge STABLE_CYCLES: commit.
  - Outputs and `oUpdate` are visible in the cycle after edge STABLE_CYCLES.
- A glitch of any length that changes the sample restarts the count. A strobe held for fewer than STABLE_CYCLES+1 edges never commits.
- `oUpdate` is never high on two consecutive cycles. A new commit requires at least STABLE_CYCLES edges after the previous one.
- Scan wrap-around (digit DIGITS-1 → digit 0) has no special handling. It is simply a strobe change.

## Test plan
- Reset and digit commit (STABLE_CYCLES=4, DIGITS=4): after reset, apply `iDigEn`=0001 with `iSeg`=0000110.
  - Outputs stay at reset values through edge 3.
  - After edge 4: `oUpdate`=1 for one cycle, `oDigIdx`=0, `oValue[3:0]`=3, `oValid`=0001.
- Full scan: rotate strobes 0001→0010→0100→1000 for 8 cycles each, carrying patterns for 1, A, D, F.
  - Expect `oValue`=16'hFDA1 and `oValid`=1111.
  - Expect exactly 4 `oUpdate` pulses per rotation.
- Glitch rejection: while settling digit 2 on 0010010, flip one segment for 1 cycle at `cnt`=2.
  - No commit occurs until 4 further stable edges have passed.
  - Then `oValue[11:8]`=2.
- Bad and blank patterns: commit 1111110 on digit 1, then 1111111 on digit 1.
  - First commit: `oErr[1]`=1, `oValid[1]`=0, nibble unchanged.
  - Second commit: `oBlank[1]`=1, `oErr[1]`=0.
- Multi-hot and zero strobes: hold `iDigEn`=0011 or 0000 for 20 cycles.
  - No `oUpdate` pulses; all outputs unchanged.
- Reset mid-operation: assert `rst_n`=0 for 1 edge at `cnt`=3 with prior committed digits.
  - All outputs return to 0.
  - After release, the held pattern commits at edge 4 relative to release.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// Reads back a multiplexed active-low 7-segment display bus: registers the bus,
// waits for each strobed digit to be stable, then decodes it into a hex nibble.
module seg7_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [0:6]            iSeg,
    input  logic [DIGITS-1:0]     iDigEn,
    output logic [4*DIGITS-1:0]   oValue,
    output logic [DIGITS-1:0]     oValid,
    output logic [DIGITS-1:0]     oBlank,
    output logic [DIGITS-1:0]     oErr,
    output logic                  oUpdate,
    output logic [2:0]            oDigIdx,
    output logic [1:0]            dbg_state
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] HELD   = 2'd2;

    localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);

    logic [0:6]        s_seg;
    logic [DIGITS-1:0] s_en;
    logic [0:6]        p_seg;
    logic [DIGITS-1:0] p_en;
    logic [1:0]        state;
    logic [7:0]        cnt;

    logic              one_hot;
    logic              changed;
    logic [3:0]        nibble;
    logic              is_hex;
    logic              is_blank;

    assign dbg_state = state;
    assign changed   = (s_en != p_en) || (s_seg != p_seg);

    always_comb begin
        int ones;
        ones = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (s_en[i]) ones = ones + 1;
        end
        one_hot = (ones == 1);
    end

    // Bit strings read left to right as segments a..g.
    always_comb begin
        nibble   = 4'h0;
        is_hex   = 1'b1;
        is_blank = 1'b0;
        case (s_seg)
            7'b0000001: nibble = 4'h0;
            7'b1001111: nibble = 4'h1;
            7'b0010010: nibble = 4'h2;
            7'b0000110: nibble = 4'h3;
            7'b1001100: nibble = 4'h4;
            7'b0100100: nibble = 4'h5;
            7'b0100000: nibble = 4'h6;
            7'b0001111: nibble = 4'h7;
            7'b0000000: nibble = 4'h8;
            7'b0000100: nibble = 4'h9;
            7'b0001000: nibble = 4'hA;
            7'b1100000: nibble = 4'hB;
            7'b0110001: nibble = 4'hC;
            7'b1000010: nibble = 4'hD;
            7'b0110000: nibble = 4'hE;
            7'b0111000: nibble = 4'hF;
            7'b1111111: begin
                is_hex   = 1'b0;
                is_blank = 1'b1;
            end
            default: is_hex = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_seg   <= 7'b1111111;
            s_en    <= '0;
            p_seg   <= 7'b1111111;
            p_en    <= '0;
            state   <= IDLE;
            cnt     <= 8'd0;
            oValue  <= '0;
            oValid  <= '0;
            oBlank  <= '0;
            oErr    <= '0;
            oUpdate <= 1'b0;
            oDigIdx <= 3'd0;
        end else begin
            s_seg   <= iSeg;
            s_en    <= iDigEn;
            p_seg   <= s_seg;
            p_en    <= s_en;
            oUpdate <= 1'b0;
            if (!one_hot) begin
                state <= IDLE;
                cnt   <= 8'd0;
            end else if (changed) begin
                state <= SETTLE;
                cnt   <= 8'd1;
            end else if (state == SETTLE) begin
                if (cnt < LAST_CNT) begin
                    cnt <= cnt + 8'd1;
                end else begin
                    state   <= HELD;
                    oUpdate <= 1'b1;
                    for (int d = 0; d < DIGITS; d++) begin
                        if (s_en[d]) begin
                            oDigIdx   <= 3'(d);
                            oValid[d] <= is_hex;
                            oBlank[d] <= is_blank;
                            oErr[d]   <= !is_hex && !is_blank;
                            if (is_hex) oValue[4*d +: 4] <= nibble;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomised and directed bench for seg7_scan_decoder, checked against a
// run-length reference model of the display bus.
module tb_seg7_scan_decoder;

    localparam int DIGITS = 4;
    localparam int SC     = 4;
    localparam int VW     = 4*DIGITS + 3*DIGITS + 1 + 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   en;
    logic [4*DIGITS-1:0] oValue;
    logic [DIGITS-1:0]   oValid, oBlank, oErr;
    logic                oUpdate;
    logic [2:0]          oDigIdx;
    logic [1:0]          dbg_state;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .iSeg(seg), .iDigEn(en),
        .oValue(oValue), .oValid(oValid), .oBlank(oBlank), .oErr(oErr),
        .oUpdate(oUpdate), .oDigIdx(oDigIdx), .dbg_state(dbg_state)
    );

    logic [6:0] hex_pat [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Reference model: a digit commits when the same one-hot sample has been
    // seen for SC consecutive edges after it was first registered.
    logic [4*DIGITS-1:0] m_value;
    logic [DIGITS-1:0]   m_valid, m_blank, m_err;
    logic                m_update;
    logic [2:0]          m_idx;
    logic [6:0]          m_seg, m_last_seg;
    logic [DIGITS-1:0]   m_en, m_last_en;
    int                  m_run;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_value = '0; m_valid = '0; m_blank = '0; m_err = '0;
            m_update = 1'b0; m_idx = 3'd0;
            m_seg = 7'h7F; m_last_seg = 7'h7F; m_en = '0; m_last_en = '0;
            m_run = 0;
        end else begin
            m_update = 1'b0;
            if ($countones(m_en) == 1) begin
                if (m_en == m_last_en && m_seg == m_last_seg) m_run = m_run + 1;
                else m_run = 1;
                if (m_run == SC) begin
                    int d;
                    int h;
                    d = 0;
                    for (int i = 0; i < DIGITS; i++) if (m_en[i]) d = i;
                    h = -1;
                    for (int k = 0; k < 16; k++) if (hex_pat[k] == m_seg) h = k;
                    m_update = 1'b1;
                    m_idx = 3'(d);
                    if (h >= 0) begin
                        m_value[4*d +: 4] = 4'(h);
                        m_valid[d] = 1'b1; m_blank[d] = 1'b0; m_err[d] = 1'b0;
                    end else if (m_seg == 7'h7F) begin
                        m_valid[d] = 1'b0; m_blank[d] = 1'b1; m_err[d] = 1'b0;
                    end else begin
                        m_valid[d] = 1'b0; m_blank[d] = 1'b0; m_err[d] = 1'b1;
                    end
                end
            end else begin
                m_run = 0;
            end
            m_last_en = m_en; m_last_seg = m_seg;
            m_en = en; m_seg = seg;
        end
    end

    function automatic logic [VW-1:0] exp_vec();
        return {m_value, m_valid, m_blank, m_err, m_update, m_idx};
    endfunction

    logic [VW-1:0] dut_vec;
    assign dut_vec = {oValue, oValid, oBlank, oErr, oUpdate, oDigIdx};

    task automatic drive(input logic [DIGITS-1:0] e, input logic [6:0] s);
        en  = e;
        seg = s;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive('0, 7'h7F);
        repeat (2) @(negedge clk);
        vectors++;
        if (dut_vec !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", dut_vec);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_idle: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_digit_commit();
        drive(4'b0001, 7'b0000110);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL commit_model c=%0d: got %h want %h", c, dut_vec, exp_vec());
            end
            if (c < 4) begin
                vectors++;
                if (dut_vec !== '0) begin
                    miscompares++;
                    $display("FAIL commit_early c=%0d: got %h want 0", c, dut_vec);
                end
            end else if (c == 4) begin
                vectors++;
                if ({oUpdate, oDigIdx, oValue[3:0], oValid} !== {1'b1, 3'd0, 4'h3, 4'b0001}) begin
                    miscompares++;
                    $display("FAIL commit_edge4: got upd=%b idx=%0d val=%h valid=%b want 1 0 3 0001",
                             oUpdate, oDigIdx, oValue[3:0], oValid);
                end
            end else begin
                vectors++;
                if (oUpdate !== 1'b0) begin
                    miscompares++;
                    $display("FAIL commit_single_pulse c=%0d: got %b want 0", c, oUpdate);
                end
            end
        end
    endtask

    task automatic test_full_scan();
        logic [6:0] pats [4];
        pats[0] = 7'b1001111; pats[1] = 7'b0001000;
        pats[2] = 7'b1000010; pats[3] = 7'b0111000;
        for (int r = 0; r < 2; r++) begin
            int pulses;
            pulses = 0;
            for (int d = 0; d < DIGITS; d++) begin
                drive(4'(1 << d), pats[d]);
                for (int c = 0; c < 8; c++) begin
                    @(negedge clk);
                    if (oUpdate === 1'b1) pulses++;
                    vectors++;
                    if (dut_vec !== exp_vec()) begin
                        miscompares++;
                        $display("FAIL scan_model r=%0d d=%0d c=%0d: got %h want %h",
                                 r, d, c, dut_vec, exp_vec());
                    end
                end
            end
            vectors++;
            if (pulses != 4) begin
                miscompares++;
                $display("FAIL scan_pulses r=%0d: got %0d want 4", r, pulses);
            end
            vectors++;
            if ({oValue, oValid} !== {16'hFDA1, 4'b1111}) begin
                miscompares++;
                $display("FAIL scan_value r=%0d: got %h/%b want fda1/1111", r, oValue, oValid);
            end
        end
    endtask

    task automatic test_glitch();
        int pulse_at;
        drive(4'b0100, 7'b0010010);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (oUpdate !== 1'b0 || dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL glitch_pre c=%0d: got %h want %h", c, dut_vec, exp_vec());
            end
        end
        drive(4'b0100, 7'b0010011);
        @(negedge clk);
        drive(4'b0100, 7'b0010010);
        pulse_at = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (oUpdate === 1'b1 && pulse_at < 0) pulse_at = c;
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL glitch_model c=%0d: got %h want %h", c, dut_vec, exp_vec());
            end
        end
        vectors++;
        if (pulse_at != 4) begin
            miscompares++;
            $display("FAIL glitch_pulse_pos: got %0d want 4", pulse_at);
        end
        vectors++;
        if ({oValue[11:8], oValid[2]} !== {4'h2, 1'b1}) begin
            miscompares++;
            $display("FAIL glitch_value: got %h/%b want 2/1", oValue[11:8], oValid[2]);
        end
    endtask

    task automatic test_bad_blank();
        drive(4'b0010, 7'b1111110);
        repeat (8) @(negedge clk);
        vectors++;
        if ({oErr[1], oValid[1], oBlank[1], oValue[7:4]} !== {1'b1, 1'b0, 1'b0, 4'hA}) begin
            miscompares++;
            $display("FAIL bad_pattern: got err=%b valid=%b blank=%b nib=%h want 1 0 0 a",
                     oErr[1], oValid[1], oBlank[1], oValue[7:4]);
        end
        drive(4'b0010, 7'b1111111);
        repeat (8) @(negedge clk);
        vectors++;
        if ({oErr[1], oValid[1], oBlank[1], oValue[7:4]} !== {1'b0, 1'b0, 1'b1, 4'hA}) begin
            miscompares++;
            $display("FAIL blank_pattern: got err=%b valid=%b blank=%b nib=%h want 0 0 1 a",
                     oErr[1], oValid[1], oBlank[1], oValue[7:4]);
        end
        vectors++;
        if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL bad_blank_model: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_bad_strobes();
        logic [VW-1:0] saved;
        logic [DIGITS-1:0] strobes [2];
        int pulses;
        strobes[0] = 4'b0011; strobes[1] = 4'b0000;
        saved  = exp_vec();
        pulses = 0;
        for (int k = 0; k < 2; k++) begin
            drive(strobes[k], hex_pat[$urandom_range(0, 15)]);
            repeat (20) begin
                @(negedge clk);
                if (oUpdate === 1'b1) pulses++;
            end
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL bad_strobe_pulses: got %0d want 0", pulses);
        end
        vectors++;
        if (dut_vec !== saved) begin
            miscompares++;
            $display("FAIL bad_strobe_hold: got %h want %h", dut_vec, saved);
        end
    endtask

    task automatic test_reset_mid();
        int pulse_at;
        int pulses;
        drive(4'b0001, 7'b0100100);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (dut_vec !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_clear: got %h want 0", dut_vec);
        end
        rst_n = 1'b1;
        pulse_at = -1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (oUpdate === 1'b1) begin
                pulses++;
                if (pulse_at < 0) pulse_at = c;
            end
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_mid_model c=%0d: got %h want %h", c, dut_vec, exp_vec());
            end
        end
        vectors++;
        if (pulse_at != 4 || pulses != 1) begin
            miscompares++;
            $display("FAIL reset_mid_commit: got pos=%0d n=%0d want pos=4 n=1", pulse_at, pulses);
        end
        vectors++;
        if ({oValue, oValid} !== {16'h0005, 4'b0001}) begin
            miscompares++;
            $display("FAIL reset_mid_value: got %h/%b want 0005/0001", oValue, oValid);
        end
    endtask

    task automatic test_random();
        logic prev_upd;
        prev_upd = 1'b0;
        for (int n = 0; n < 250; n++) begin
            int r;
            int hold;
            logic [DIGITS-1:0] e;
            logic [6:0] s;
            r = $urandom_range(0, 9);
            if (r <= 6)      e = 4'(1 << $urandom_range(0, DIGITS - 1));
            else if (r == 7) e = '0;
            else if (r == 8) e = 4'($urandom_range(0, 15));
            else             e = en;
            r = $urandom_range(0, 7);
            if (r <= 5)      s = hex_pat[$urandom_range(0, 15)];
            else if (r == 6) s = 7'h7F;
            else             s = 7'($urandom_range(0, 127));
            drive(e, s);
            hold = $urandom_range(1, 7);
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                vectors++;
                if (dut_vec !== exp_vec() || (prev_upd && oUpdate)) begin
                    miscompares++;
                    $display("FAIL random n=%0d c=%0d: got %h want %h", n, c, dut_vec, exp_vec());
                end
                prev_upd = oUpdate;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive('0, 7'h7F);
        @(negedge clk);
        test_reset();
        test_digit_commit();
        test_full_scan();
        test_glitch();
        test_bad_blank();
        test_bad_strobes();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
